// File: rtl/mmu_sequencer.sv
// mmu_sequencer: initiator-side controller for the mmu systolic unit.
// Each job moves one weight tile into the MMU (push, load, swap), then
// streams N activation tiles through it. For every tile it pushes the
// data, starts a multiply, pops the result and hands it to the host.
//
// Handshake semantics, used on every host stream (cmd, w, d, r):
//   A transfer happens on the rising clock edge where valid && ready are
//   both 1. Valid never waits on ready. Ready may depend on valid.
// The MMU side uses rdy/strobe pairs instead. A strobe is a single-cycle
// pulse, decoded combinationally from the state, and it is only raised in
// a cycle where the matching MMU rdy is 1.
module mmu_sequencer #(
   parameter int SIZE      = 2,
   parameter int MAX_TILES = 16,
   parameter int CNT_W     = $clog2(MAX_TILES + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   // job command
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [CNT_W-1:0]           cmd_n_tiles,
   // host weight stream
   input  logic                       w_valid,
   output logic                       w_ready,
   input  logic [8*SIZE*SIZE-1:0]     w_data,
   // host activation stream
   input  logic                       d_valid,
   output logic                       d_ready,
   input  logic [8*SIZE*SIZE-1:0]     d_data,
   // host result stream
   output logic                       r_valid,
   input  logic                       r_ready,
   output logic [32*SIZE*SIZE-1:0]    r_data,
   // status
   output logic                       busy,
   output logic                       job_done,
   output logic                       err,
   // MMU weight path
   output logic [8*SIZE*SIZE-1:0]     new_weight_out,
   input  logic                       new_weight_rdy,
   output logic                       new_weight_push,
   // MMU data path
   output logic [8*SIZE*SIZE-1:0]     data_out,
   input  logic                       data_in_rdy,
   output logic                       data_in_push,
   // MMU result path
   input  logic [32*SIZE*SIZE-1:0]    acc_in,
   input  logic                       acc_out_rdy,
   output logic                       acc_out_pop,
   // MMU control
   input  logic                       weight_ld_rdy,
   output logic                       weight_ld_start,
   input  logic                       weight_ld_done,
   output logic                       weight_swap,
   input  logic                       mult_rdy,
   output logic                       mult_start,
   input  logic                       mult_done,
   // debug visibility
   output logic [3:0]                 fsm_state,
   output logic [CNT_W-1:0]           tile_cnt
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_W_PUSH  = 4'd1,
      S_W_LOAD  = 4'd2,
      S_W_WAIT  = 4'd3,
      S_W_SWAP  = 4'd4,
      S_D_PUSH  = 4'd5,
      S_M_START = 4'd6,
      S_M_WAIT  = 4'd7,
      S_R_POP   = 4'd8,
      S_DONE    = 4'd9
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] n_reg;
   logic [CNT_W-1:0] cnt;
   logic             cmd_legal;
   logic             r_accept;

   assign cmd_legal = (cmd_n_tiles != '0) && (cmd_n_tiles <= CNT_W'(MAX_TILES));
   assign r_accept  = (state == S_R_POP) && r_valid && r_ready;
   assign busy      = (state != S_IDLE);
   assign fsm_state = state;
   assign tile_cnt  = cnt;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and single-cycle strobes. Strobes are held low
   // during reset, so an abandoned job issues nothing in the reset cycle.
   always_comb begin
      next_state      = state;
      cmd_ready       = (state == S_IDLE);
      w_ready         = 1'b0;
      d_ready         = 1'b0;
      new_weight_push = 1'b0;
      data_in_push    = 1'b0;
      weight_ld_start = 1'b0;
      weight_swap     = 1'b0;
      mult_start      = 1'b0;
      acc_out_pop     = 1'b0;
      job_done        = 1'b0;
      new_weight_out  = '0;
      data_out        = '0;
      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_legal) next_state = S_W_PUSH;
         end
         S_W_PUSH: begin
            w_ready         = new_weight_rdy;
            new_weight_push = w_valid && new_weight_rdy;
            new_weight_out  = w_data;
            if (w_valid && new_weight_rdy) next_state = S_W_LOAD;
         end
         S_W_LOAD: begin
            weight_ld_start = weight_ld_rdy;
            if (weight_ld_rdy) next_state = S_W_WAIT;
         end
         S_W_WAIT: begin
            // ld_start was issued in W_LOAD, so a done seen then is ignored
            if (weight_ld_done) next_state = S_W_SWAP;
         end
         S_W_SWAP: begin
            weight_swap = 1'b1;
            next_state  = S_D_PUSH;
         end
         S_D_PUSH: begin
            d_ready      = data_in_rdy;
            data_in_push = d_valid && data_in_rdy;
            data_out     = d_data;
            if (d_valid && data_in_rdy) next_state = S_M_START;
         end
         S_M_START: begin
            mult_start = mult_rdy;
            if (mult_rdy) next_state = S_M_WAIT;
         end
         S_M_WAIT: begin
            if (mult_done) next_state = S_R_POP;
         end
         S_R_POP: begin
            // only one result is ever held, so no pop while r_data is full
            acc_out_pop = acc_out_rdy && !r_valid;
            if (r_valid && r_ready) begin
               next_state = ((cnt + CNT_W'(1)) == n_reg) ? S_DONE : S_D_PUSH;
            end
         end
         S_DONE: begin
            job_done   = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
      if (rst) begin
         w_ready         = 1'b0;
         d_ready         = 1'b0;
         new_weight_push = 1'b0;
         data_in_push    = 1'b0;
         weight_ld_start = 1'b0;
         weight_swap     = 1'b0;
         mult_start      = 1'b0;
         acc_out_pop     = 1'b0;
         job_done        = 1'b0;
      end
   end

   // Job bookkeeping: tile count, sticky error, and the result holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_reg   <= '0;
         cnt     <= '0;
         err     <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (state == S_IDLE && cmd_valid) begin
            if (cmd_legal) begin
               n_reg <= cmd_n_tiles;
               cnt   <= '0;
               err   <= 1'b0;
            end else begin
               err <= 1'b1;
            end
         end
         if (acc_out_pop) begin
            r_data  <= acc_in;
            r_valid <= 1'b1;
         end
         if (r_accept) begin
            r_valid <= 1'b0;
            cnt     <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mmu_sequencer.sv
// tb_mmu_sequencer: directed bench for mmu_sequencer with a small
// behavioural MMU (2-cycle weight load, 3-cycle multiply).
module tb_mmu_sequencer;

   localparam int SIZE      = 2;
   localparam int MAX_TILES = 16;
   localparam int CNT_W     = 5;

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_W_PUSH  = 4'd1;
   localparam logic [3:0] S_D_PUSH  = 4'd5;
   localparam logic [3:0] S_M_WAIT  = 4'd7;

   // weight tiles, element [r][c] at byte r*2+c
   localparam logic [31:0] W1 = {8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [31:0] W3 = {8'd2, 8'd0, 8'd0, 8'd2};
   // activation tiles
   localparam logic [31:0] TA = {8'd8, 8'd7, 8'd6, 8'd5};
   localparam logic [31:0] TB = {8'd1, 8'd0, 8'd0, 8'd1};
   localparam logic [31:0] TC = {8'd3, 8'd0, 8'd1, 8'd2};
   // hand-computed products D x W
   localparam logic [127:0] RA_W1 = {32'd46, 32'd31, 32'd34, 32'd23};
   localparam logic [127:0] RB_W1 = {32'd4, 32'd3, 32'd2, 32'd1};
   localparam logic [127:0] RC_W1 = {32'd12, 32'd9, 32'd8, 32'd5};
   localparam logic [127:0] RA_W3 = {32'd16, 32'd14, 32'd12, 32'd10};

   logic              clk;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [CNT_W-1:0]  cmd_n_tiles;
   logic              w_valid;
   logic              w_ready;
   logic [31:0]       w_data;
   logic              d_valid;
   logic              d_ready;
   logic [31:0]       d_data;
   logic              r_valid;
   logic              r_ready;
   logic [127:0]      r_data;
   logic              busy;
   logic              job_done;
   logic              err;
   logic [31:0]       new_weight_out;
   logic              new_weight_rdy;
   logic              new_weight_push;
   logic [31:0]       data_out;
   logic              data_in_rdy;
   logic              data_in_push;
   logic [127:0]      acc_in;
   logic              acc_out_rdy;
   logic              acc_out_pop;
   logic              weight_ld_rdy;
   logic              weight_ld_start;
   logic              weight_ld_done;
   logic              weight_swap;
   logic              mult_rdy;
   logic              mult_start;
   logic              mult_done;
   logic [3:0]        fsm_state;
   logic [CNT_W-1:0]  tile_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [127:0] exp_q[$];
   logic [31:0]  d_tiles[16];

   mmu_sequencer #(.SIZE(SIZE), .MAX_TILES(MAX_TILES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n_tiles(cmd_n_tiles),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
      .busy(busy), .job_done(job_done), .err(err),
      .new_weight_out(new_weight_out), .new_weight_rdy(new_weight_rdy),
      .new_weight_push(new_weight_push),
      .data_out(data_out), .data_in_rdy(data_in_rdy), .data_in_push(data_in_push),
      .acc_in(acc_in), .acc_out_rdy(acc_out_rdy), .acc_out_pop(acc_out_pop),
      .weight_ld_rdy(weight_ld_rdy), .weight_ld_start(weight_ld_start),
      .weight_ld_done(weight_ld_done), .weight_swap(weight_swap),
      .mult_rdy(mult_rdy), .mult_start(mult_start), .mult_done(mult_done),
      .fsm_state(fsm_state), .tile_cnt(tile_cnt)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural MMU ----------------
   logic [31:0]  m_wbuf, m_wact, m_dbuf;
   logic [1:0]   ld_sh;
   logic [2:0]   ml_sh;
   logic [127:0] m_res;
   logic         m_avail;
   logic         acc_force;

   function automatic logic [127:0] mat_mul(input logic [31:0] d, input logic [31:0] w);
      logic [127:0] r;
      logic [31:0]  s;
      r = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            s = '0;
            for (int k = 0; k < 2; k++) begin
               s = s + 32'(d[(i*2+k)*8 +: 8]) * 32'(w[(k*2+j)*8 +: 8]);
            end
            r[(i*2+j)*32 +: 32] = s;
         end
      end
      return r;
   endfunction

   assign weight_ld_done = ld_sh[1];
   assign mult_done      = ml_sh[2];
   assign acc_out_rdy    = m_avail || acc_force;
   assign acc_in         = m_res;

   always @(posedge clk) begin
      if (rst) begin
         m_wbuf  <= '0;
         m_wact  <= '0;
         m_dbuf  <= '0;
         ld_sh   <= '0;
         ml_sh   <= '0;
         m_res   <= '0;
         m_avail <= 1'b0;
      end else begin
         if (new_weight_push) m_wbuf <= new_weight_out;
         if (weight_swap)     m_wact <= m_wbuf;
         if (data_in_push)    m_dbuf <= data_out;
         ld_sh <= {ld_sh[0], weight_ld_start};
         ml_sh <= {ml_sh[1:0], mult_start};
         if (mult_start) m_res <= mat_mul(m_dbuf, m_wact);
         if (ml_sh[2]) m_avail <= 1'b1;
         else if (acc_out_pop) m_avail <= 1'b0;
      end
   end

   // ---------------- strobe monitor ----------------
   int ev_q[$];
   int n_pop = 0;
   int n_done = 0;
   int n_viol = 0;
   int n_strobe = 0;

   always @(posedge clk) begin
      if (new_weight_push) ev_q.push_back(1);
      if (weight_ld_start) ev_q.push_back(2);
      if (weight_swap)     ev_q.push_back(3);
      if (data_in_push)    ev_q.push_back(4);
      if (mult_start)      ev_q.push_back(5);
      if (acc_out_pop)     ev_q.push_back(6);
      if (job_done)        ev_q.push_back(7);
      if (acc_out_pop) n_pop++;
      if (job_done)    n_done++;
      if (new_weight_push || weight_ld_start || weight_swap || data_in_push ||
          mult_start || acc_out_pop || job_done) n_strobe++;
      if ((new_weight_push && !new_weight_rdy) || (data_in_push && !data_in_rdy) ||
          (weight_ld_start && !weight_ld_rdy) || (mult_start && !mult_rdy) ||
          (acc_out_pop && !acc_out_rdy) || (acc_out_pop && r_valid)) n_viol++;
   end

   // ---------------- check and driver tasks ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] strobes();
      return {new_weight_push, data_in_push, acc_out_pop, weight_ld_start,
              weight_swap, mult_start, job_done, w_ready, d_ready};
   endfunction

   // holds cmd_valid for exactly one rising edge; returns at negedge+1
   task automatic send_cmd(input int n);
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_n_tiles = CNT_W'(n);
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
   endtask

   // host side of a job; stops at job_done, or in M_WAIT of tile abort_tile
   task automatic run_job(input logic [31:0] wt, input int n, input int stall_tile,
                          input int stall_len, input int abort_tile, output int r_cnt);
      int  d_idx;
      int  stall;
      int  cyc;
      bit  fin;
      bit  w_done;
      d_idx = 0; r_cnt = 0; stall = 0; cyc = 0; fin = 0; w_done = 0;
      w_valid = (fsm_state == S_W_PUSH);
      w_data  = wt;
      d_valid = 1'b1;
      d_data  = d_tiles[0];
      while (!fin && cyc < 400) begin
         r_ready = !(r_valid && r_cnt == stall_tile && stall < stall_len);
         if (!r_ready) stall++;
         #1;
         if (abort_tile >= 0 && d_idx == abort_tile + 1 && fsm_state == S_M_WAIT) begin
            fin = 1;
         end else begin
            if (w_valid && w_ready) w_done = 1;
            if (d_valid && d_ready) d_idx++;
            if (r_valid && r_ready) begin
               if (exp_q.size() > 0) check("result_data", r_data, exp_q.pop_front());
               else check("result_unexpected", 128'(r_cnt), 128'(n));
               r_cnt++;
            end
            if (job_done) fin = 1;
            @(negedge clk);
            if (w_done) w_valid = 1'b0;
            if (d_idx < n && d_idx < 16) d_data = d_tiles[d_idx];
            else d_valid = 1'b0;
            cyc++;
         end
      end
      check("job_in_budget", 128'(cyc < 400), 128'(1));
      w_valid = 1'b0;
      d_valid = 1'b0;
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int rc;
      int ev_base, pop_base, done_base, strobe_base, k;

      rst = 1'b1; cmd_valid = 1'b0; cmd_n_tiles = '0;
      w_valid = 1'b0; w_data = '0; d_valid = 1'b0; d_data = '0; r_ready = 1'b1;
      new_weight_rdy = 1'b1; data_in_rdy = 1'b1; weight_ld_rdy = 1'b1; mult_rdy = 1'b1;
      acc_force = 1'b0;
      for (int i = 0; i < 16; i++) d_tiles[i] = '0;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
      check("rst_strobes", 128'(strobes()), 128'(0));
      check("rst_r_valid", 128'(r_valid), 128'(0));
      check("rst_err", 128'(err), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_state", 128'(fsm_state), 128'(S_IDLE));
      check("rst_tile_cnt", 128'(tile_cnt), 128'(0));
      check("rst_r_data", r_data, 128'(0));
      check("rst_buses", 128'({new_weight_out, data_out}), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      // single-tile job: strobe order and result
      d_tiles[0] = TA;
      exp_q.push_back(RA_W1);
      ev_base = ev_q.size(); done_base = n_done;
      send_cmd(1);
      check("n1_busy", 128'(busy), 128'(1));
      check("n1_state_w_push", 128'(fsm_state), 128'(S_W_PUSH));
      run_job(W1, 1, -1, 0, -1, rc);
      @(negedge clk); #1;
      check("n1_results", 128'(rc), 128'(1));
      check("n1_idle", 128'(fsm_state), 128'(S_IDLE));
      check("n1_tile_cnt", 128'(tile_cnt), 128'(1));
      check("n1_done_once", 128'(n_done - done_base), 128'(1));
      check("n1_strobe_count", 128'(ev_q.size() - ev_base), 128'(7));
      for (int i = 0; i < 7; i++) begin
         if (ev_base + i < ev_q.size()) check("n1_strobe_order", 128'(ev_q[ev_base+i]), 128'(i + 1));
      end

      // three tiles, r_ready low 5 cycles on tile 2, MMU claims more results
      d_tiles[0] = TA; d_tiles[1] = TB; d_tiles[2] = TC;
      exp_q.push_back(RA_W1); exp_q.push_back(RB_W1); exp_q.push_back(RC_W1);
      pop_base = n_pop; done_base = n_done;
      acc_force = 1'b1;
      send_cmd(3);
      run_job(W1, 3, 1, 5, -1, rc);
      @(negedge clk); #1;
      acc_force = 1'b0;
      check("n3_results", 128'(rc), 128'(3));
      check("n3_pops", 128'(n_pop - pop_base), 128'(3));
      check("n3_done_once", 128'(n_done - done_base), 128'(1));
      check("n3_tile_cnt", 128'(tile_cnt), 128'(3));
      check("n3_idle", 128'(fsm_state), 128'(S_IDLE));
      check("n3_r_data_held", r_data, RC_W1);

      // MMU FIFO full on weight and data paths for 4 cycles
      d_tiles[0] = TA;
      exp_q.push_back(RA_W1);
      new_weight_rdy = 1'b0;
      send_cmd(1);
      w_valid = 1'b1; w_data = W1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("wfull_w_ready", 128'(w_ready), 128'(0));
         check("wfull_push", 128'(new_weight_push), 128'(0));
         @(negedge clk);
      end
      new_weight_rdy = 1'b1;
      #1;
      check("wfree_w_ready", 128'(w_ready), 128'(1));
      check("wfree_push", 128'(new_weight_push), 128'(1));
      check("wfree_bus", 128'(new_weight_out), 128'(W1));
      @(negedge clk);
      w_valid = 1'b0;
      data_in_rdy = 1'b0;
      #1;
      k = 0;
      while (fsm_state !== S_D_PUSH && k < 20) begin
         @(negedge clk); #1; k++;
      end
      check("reach_d_push", 128'(fsm_state), 128'(S_D_PUSH));
      @(negedge clk);
      d_valid = 1'b1; d_data = TA;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("dfull_d_ready", 128'(d_ready), 128'(0));
         check("dfull_push", 128'(data_in_push), 128'(0));
         @(negedge clk);
      end
      data_in_rdy = 1'b1;
      #1;
      check("dfree_d_ready", 128'(d_ready), 128'(1));
      check("dfree_push", 128'(data_in_push), 128'(1));
      check("dfree_bus", 128'(data_out), 128'(TA));
      run_job(W1, 1, -1, 0, -1, rc);
      @(negedge clk); #1;
      check("rdy_results", 128'(rc), 128'(1));
      check("rdy_idle", 128'(fsm_state), 128'(S_IDLE));

      // illegal tile counts, then a legal job clears err
      strobe_base = n_strobe;
      send_cmd(0);
      check("n0_err", 128'(err), 128'(1));
      check("n0_idle", 128'(fsm_state), 128'(S_IDLE));
      send_cmd(MAX_TILES + 1);
      check("n17_err", 128'(err), 128'(1));
      check("n17_idle", 128'(fsm_state), 128'(S_IDLE));
      check("n17_cmd_ready", 128'(cmd_ready), 128'(1));
      check("illegal_no_strobes", 128'(n_strobe - strobe_base), 128'(0));
      d_tiles[0] = TA;
      exp_q.push_back(RA_W3);
      send_cmd(1);
      check("legal_err_clear", 128'(err), 128'(0));
      check("legal_runs", 128'(fsm_state), 128'(S_W_PUSH));
      run_job(W3, 1, -1, 0, -1, rc);
      @(negedge clk); #1;
      check("legal_results", 128'(rc), 128'(1));

      // reset in M_WAIT of tile 2 of 3
      d_tiles[0] = TA; d_tiles[1] = TB; d_tiles[2] = TC;
      exp_q.push_back(RA_W1);
      pop_base = n_pop; done_base = n_done;
      send_cmd(3);
      run_job(W1, 3, -1, 0, 1, rc);
      check("abort_in_m_wait", 128'(fsm_state), 128'(S_M_WAIT));
      rst = 1'b1;
      #1;
      check("abort_rst_strobes", 128'(strobes()), 128'(0));
      @(negedge clk); #1;
      check("abort_idle", 128'(fsm_state), 128'(S_IDLE));
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_r_valid", 128'(r_valid), 128'(0));
      check("abort_tile_cnt", 128'(tile_cnt), 128'(0));
      check("abort_pops", 128'(n_pop - pop_base), 128'(1));
      check("abort_no_done", 128'(n_done - done_base), 128'(0));
      check("abort_results", 128'(rc), 128'(1));
      rst = 1'b0;

      // reset while a weight push would fire: strobe suppressed
      send_cmd(1);
      w_valid = 1'b1; w_data = W1;
      #1;
      check("wrst_push_before", 128'(new_weight_push), 128'(1));
      rst = 1'b1;
      strobe_base = n_strobe;
      #1;
      check("wrst_push_gated", 128'(new_weight_push), 128'(0));
      check("wrst_w_ready_gated", 128'(w_ready), 128'(0));
      @(negedge clk); #1;
      check("wrst_no_strobe_logged", 128'(n_strobe - strobe_base), 128'(0));
      check("wrst_idle", 128'(fsm_state), 128'(S_IDLE));
      w_valid = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("protocol_violations", 128'(n_viol), 128'(0));
      check("exp_q_drained", 128'(exp_q.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
